// File: rtl/acc_sched_pkg.sv
// Shared types and default sizing for the accumulator-array tile scheduler.
package acc_sched_pkg;

  // Beats per tile; also the number of skew stages in the array.
  localparam int DEF_ARRAY_SIZE = 4;
  // Width of the beat index, clog2(DEF_ARRAY_SIZE).
  localparam int DEF_ADDR_WIDTH = 2;
  // Width of every tile-count field.
  localparam int DEF_TILE_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

endpackage : acc_sched_pkg

// File: rtl/dff.sv
// Plain register with synchronous active-high reset to zero.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d every cycle; reset wins.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule : dff

// File: rtl/tile_counter.sv
// Up-counter with synchronous clear (priority) and count enable; wraps.
module tile_counter
  import acc_sched_pkg::*;
#(
  parameter int WIDTH = DEF_TILE_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear beats enable, enable adds one modulo 2^WIDTH.
  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + WIDTH'(1);
  end

  dff #(.WIDTH(WIDTH)) u_count (
    .clk (clk),
    .rst (rst),
    .d   (count_d),
    .q   (count_q)
  );

  assign count = count_q;

endmodule : tile_counter

// File: rtl/acc_tile_scheduler.sv
// Job sequencer for the 4-lane skewed accumulator array: gates the upstream
// beat stream into the array, mirrors its beat counter, counts closed tiles
// reported by the array's delayed clear_out, and signals job completion.
module acc_tile_scheduler
  import acc_sched_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TILE_BITS  = DEF_TILE_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILE_BITS-1:0]  num_tiles,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  acc_valid,
  output logic                  acc_interrupt,
  input  logic [ADDR_WIDTH-1:0] selector_in,
  input  logic                  clear_in,
  output logic                  tile_done,
  output logic [TILE_BITS-1:0]  tiles_closed,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  output logic                  desync
);

  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(ARRAY_SIZE - 1);

  sched_state_e          state_d, state_q;
  logic [ADDR_WIDTH-1:0] beat_cnt_d, beat_cnt_q;
  logic [TILE_BITS-1:0]  job_tiles_d, job_tiles_q;
  logic                  underrun_d, underrun_q;
  logic                  desync_d, desync_q;

  logic [TILE_BITS-1:0]  tiles_issued_q;
  logic [TILE_BITS-1:0]  tiles_closed_q;
  logic [TILE_BITS-1:0]  tiles_closed_nxt;
  logic                  issued_en;
  logic                  cnt_clr;
  logic                  closed_en;
  logic                  closing;
  logic                  last_tile;

  // The array closes a tile in the slot where the beat index reaches the end.
  assign closing   = (beat_cnt_q == LAST_BEAT);
  assign last_tile = ((tiles_issued_q + TILE_BITS'(1)) == job_tiles_q);

  // Clear pulses count in every non-idle state, including DONE.
  assign closed_en        = clear_in && (state_q != ST_IDLE);
  assign tiles_closed_nxt = closed_en ? tiles_closed_q + TILE_BITS'(1) : tiles_closed_q;

  // Next-state, beat mirror and sticky-flag logic.
  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    job_tiles_d = job_tiles_q;
    underrun_d  = underrun_q;
    desync_d    = desync_q;
    issued_en   = 1'b0;
    cnt_clr     = 1'b0;
    in_ready    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          if (num_tiles != '0) begin
            job_tiles_d = num_tiles;
            underrun_d  = 1'b0;
            desync_d    = 1'b0;
            beat_cnt_d  = '0;
            state_d     = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        // Abort blocks the beat in its own cycle.
        in_ready = !abort;
        if (selector_in != beat_cnt_q) desync_d = 1'b1;
        if (closing) begin
          // The array closes regardless of valid; an empty final slot is short.
          beat_cnt_d = '0;
          issued_en  = 1'b1;
          if (!(in_valid && in_ready)) underrun_d = 1'b1;
        end else if (in_valid && in_ready) begin
          beat_cnt_d = beat_cnt_q + ADDR_WIDTH'(1);
        end
        if (abort)                     state_d = ST_FLUSH;
        else if (closing && last_tile) state_d = ST_DRAIN;
      end

      ST_FLUSH: begin
        // The interrupt closes a partial tile only if one is open.
        if (beat_cnt_q != '0) issued_en = 1'b1;
        beat_cnt_d = '0;
        state_d    = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (tiles_closed_nxt == tiles_issued_q) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  dff #(.WIDTH(ADDR_WIDTH)) u_beat_cnt (
    .clk (clk), .rst (rst), .d (beat_cnt_d), .q (beat_cnt_q)
  );

  dff #(.WIDTH(TILE_BITS)) u_job_tiles (
    .clk (clk), .rst (rst), .d (job_tiles_d), .q (job_tiles_q)
  );

  dff #(.WIDTH(1)) u_underrun (
    .clk (clk), .rst (rst), .d (underrun_d), .q (underrun_q)
  );

  dff #(.WIDTH(1)) u_desync (
    .clk (clk), .rst (rst), .d (desync_d), .q (desync_q)
  );

  tile_counter #(.WIDTH(TILE_BITS)) u_tiles_issued (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (issued_en),
    .count (tiles_issued_q)
  );

  tile_counter #(.WIDTH(TILE_BITS)) u_tiles_closed (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (closed_en),
    .count (tiles_closed_q)
  );

  assign acc_valid     = in_valid && in_ready;
  assign acc_interrupt = (state_q == ST_FLUSH);
  assign tile_done     = closed_en;
  assign tiles_closed  = tiles_closed_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign underrun      = underrun_q;
  assign desync        = desync_q;

endmodule : acc_tile_scheduler

// File: tb/tb_acc_tile_scheduler.sv
// Directed bench for acc_tile_scheduler with a behavioural accumulator array.
module tb_acc_tile_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_tiles;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic       acc_valid;
  logic       acc_interrupt;
  logic [1:0] selector_in;
  logic       clear_in;
  logic       tile_done;
  logic [7:0] tiles_closed;
  logic       busy;
  logic       done;
  logic       underrun;
  logic       desync;

  int errors = 0;
  int checks = 0;

  acc_tile_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_tiles     (num_tiles),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .acc_valid     (acc_valid),
    .acc_interrupt (acc_interrupt),
    .selector_in   (selector_in),
    .clear_in      (clear_in),
    .tile_done     (tile_done),
    .tiles_closed  (tiles_closed),
    .busy          (busy),
    .done          (done),
    .underrun      (underrun),
    .desync        (desync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: selector advances per valid beat, closes at index 3 or on an
  // interrupt with an open tile; clear_out appears 4 cycles after the close.
  logic [1:0] sel;
  logic [3:0] pipe;
  logic       skip_req;

  always @(posedge clk) begin
    if (rst) begin
      sel  <= 2'd0;
      pipe <= 4'd0;
    end else begin
      pipe <= {pipe[2:0], (sel == 2'd3) || (acc_interrupt && sel != 2'd0)};
      if (sel == 2'd3 || acc_interrupt) sel <= 2'd0;
      else if (acc_valid)               sel <= (skip_req && sel == 2'd0) ? 2'd2 : sel + 2'd1;
    end
  end

  assign selector_in = sel;
  assign clear_in    = pipe[3];

  // Event bookkeeping, sampled mid-cycle by cyc().
  int cyc_n = 0;
  int n_valid, n_td, n_int, n_done, n_busy;
  int t_int, t_done;
  int td_t [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_td = 0; n_int = 0; n_done = 0; n_busy = 0;
    t_int = -1; t_done = -1;
    for (int i = 0; i < 8; i++) td_t[i] = -1;
  endtask

  // Sample the current cycle (inputs already driven), then move to next negedge.
  task automatic cyc();
    #1;
    if (acc_valid)     n_valid++;
    if (busy)          n_busy++;
    if (acc_interrupt) begin n_int++; t_int = cyc_n; end
    if (done)          begin n_done++; t_done = cyc_n; end
    if (tile_done) begin
      if (n_td < 8) td_t[n_td] = cyc_n;
      n_td++;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) cyc();
  endtask

  int s;

  initial begin
    rst = 1'b1; start = 1'b0; num_tiles = 8'd0; abort = 1'b0;
    in_valid = 1'b0; skip_req = 1'b0;
    clear_counts();
    cyc(); cyc();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tiles_closed", tiles_closed, 0);
    check("rst_flags", {underrun, desync, acc_interrupt, tile_done}, 0);
    rst = 1'b0;
    cyc();

    // Two full tiles with continuous beats.
    clear_counts();
    s = cyc_n; in_valid = 1'b1; num_tiles = 8'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(40);
    in_valid = 1'b0;
    check("t1_done_seen", n_done, 1);
    check("t1_valid_beats", n_valid, 8);
    check("t1_tile_done_cnt", n_td, 2);
    check("t1_td0_cycle", td_t[0], s + 8);
    check("t1_td1_cycle", td_t[1], s + 12);
    check("t1_done_cycle", t_done, s + 13);
    check("t1_tiles_closed", tiles_closed, 2);
    check("t1_flags", {underrun, desync}, 0);
    check("t1_idle", busy, 0);

    // One tile, final slot empty.
    clear_counts();
    s = cyc_n; num_tiles = 8'd1; start = 1'b1;
    cyc();
    start = 1'b0; in_valid = 1'b1;
    cyc(); cyc(); cyc();
    in_valid = 1'b0;
    wait_done(30);
    check("t2_valid_beats", n_valid, 3);
    check("t2_underrun", underrun, 1);
    check("t2_tile_done_cnt", n_td, 1);
    check("t2_td0_cycle", td_t[0], s + 8);
    check("t2_done_cycle", t_done, s + 9);

    // Abort after two beats of the first of three tiles.
    clear_counts();
    s = cyc_n; num_tiles = 8'd3; in_valid = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    wait_done(30);
    in_valid = 1'b0;
    check("t3_valid_beats", n_valid, 2);
    check("t3_int_count", n_int, 1);
    check("t3_int_cycle", t_int, s + 4);
    check("t3_tile_done_cnt", n_td, 1);
    check("t3_td0_cycle", td_t[0], s + 8);
    check("t3_done_cycle", t_done, s + 9);
    check("t3_tiles_closed", tiles_closed, 1);

    // Empty job.
    clear_counts();
    s = cyc_n; num_tiles = 8'd0; in_valid = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    in_valid = 1'b0;
    check("t4_done_cycle", t_done, s + 1);
    check("t4_done_cnt", n_done, 1);
    check("t4_busy_cycles", n_busy, 1);
    check("t4_valid_beats", n_valid, 0);
    check("t4_tiles_closed", tiles_closed, 0);

    // Array selector skips a value; final slot also empty.
    clear_counts();
    s = cyc_n; num_tiles = 8'd1; start = 1'b1;
    cyc();
    start = 1'b0; in_valid = 1'b1; skip_req = 1'b1;
    cyc();
    skip_req = 1'b0;
    check("t5_desync_before", desync, 0);
    cyc();
    check("t5_desync_set", desync, 1);
    cyc();
    in_valid = 1'b0;
    cyc();
    wait_done(30);
    check("t5_done_cycle", t_done, s + 8);
    check("t5_flags_set", {underrun, desync}, 2'b11);
    check("t5_tiles_closed", tiles_closed, 1);

    // Next start clears both sticky flags; job runs clean.
    clear_counts();
    s = cyc_n; num_tiles = 8'd1; in_valid = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    check("t5b_flags_cleared", {underrun, desync}, 0);
    wait_done(30);
    in_valid = 1'b0;
    check("t5b_done_cycle", t_done, s + 9);
    check("t5b_flags_clean", {underrun, desync}, 0);

    // Reset at beat 2 of tile 1.
    clear_counts();
    s = cyc_n; num_tiles = 8'd2; in_valid = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t6_outs_zero",
          {in_ready, acc_valid, acc_interrupt, tile_done, tiles_closed, busy, done, underrun, desync}, 0);
    clear_counts();
    repeat (12) cyc();
    check("t6_no_done", n_done, 0);
    check("t6_no_tile_done", n_td, 0);
    check("t6_no_valid", n_valid, 0);
    clear_counts();
    s = cyc_n; num_tiles = 8'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(30);
    in_valid = 1'b0;
    check("t6_restart_done_cycle", t_done, s + 9);
    check("t6_restart_valid", n_valid, 4);
    check("t6_restart_closed", tiles_closed, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_acc_tile_scheduler
